// File: rtl/main_mem_ctrl_if.sv
// Request/response bundle between a cache memory port (master)
// and the main-memory controller (slave).
interface main_mem_ctrl_if;
   logic        req_valid;
   logic        req_wr;
   logic [31:0] req_addr;
   logic [31:0] req_wr_data;
   logic [31:0] req_rdata;
   logic        req_ready;
   logic        busy;
   logic        req_err;

   modport master (
      output req_valid, req_wr, req_addr, req_wr_data,
      input  req_rdata, req_ready, busy, req_err
   );

   modport slave (
      input  req_valid, req_wr, req_addr, req_wr_data,
      output req_rdata, req_ready, busy, req_err
   );
endinterface

// File: rtl/main_mem_ctrl.sv
// Single-outstanding, fixed-latency word memory behind the cache port.
// Optional MEM_BOUND_CHK_EN flags requests whose address exceeds the array.
//
// state | meaning
// IDLE  | waiting for req_valid; accepts and latches the request
// BUSY  | counting down the access latency
// RESP  | one-cycle req_ready pulse; array accessed on entry
// DONE  | one dead cycle absorbing the requester's valid deassert
module main_mem_ctrl #(
   parameter int DEPTH_LOG2 = 10,
   parameter int LATENCY    = 4
) (
   input logic            clk,
   input logic            rst,
   main_mem_ctrl_if.slave bus
);
   localparam int         DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                  state, state_nxt;
   logic [7:0]              cnt;
   logic                    lat_wr;
   logic [DEPTH_LOG2-1:0]   lat_idx;
   logic [31:0]             lat_wdata;
   logic [31:0]             rdata_q;
   logic                    accept;
   logic                    enter_resp;
   logic                    acc_wr;
   logic [DEPTH_LOG2-1:0]   acc_idx;
   logic [31:0]             acc_wdata;
   logic                    acc_oor;
   logic                    unused_bits;

   // Zero contents at time 0 so cache bring-up reads defined data.
   logic [31:0] mem [0:DEPTH-1] = '{default: 32'h0};

`ifdef MEM_BOUND_CHK_EN
   logic lat_oor;
   logic oor_now;
   assign oor_now     = |bus.req_addr[31:DEPTH_LOG2+2];
   assign acc_oor     = (state == S_IDLE) ? oor_now : lat_oor;
   assign bus.req_err = (state == S_RESP) && lat_oor;

   always_ff @(posedge clk) begin
      if (rst)         lat_oor <= 1'b0;
      else if (accept) lat_oor <= oor_now;
   end
`else
   assign acc_oor     = 1'b0;
   assign bus.req_err = 1'b0;
`endif

   assign unused_bits = ^bus.req_addr[1:0] ^ ^bus.req_addr[31:DEPTH_LOG2+2];

   assign accept     = (state == S_IDLE) && bus.req_valid;
   assign enter_resp = (state_nxt == S_RESP);

   // With LATENCY=1 the array is accessed on the acceptance edge itself,
   // before the latches hold the request, so use the live inputs then.
   assign acc_wr    = (state == S_IDLE) ? bus.req_wr                        : lat_wr;
   assign acc_idx   = (state == S_IDLE) ? bus.req_addr[DEPTH_LOG2+1:2]      : lat_idx;
   assign acc_wdata = (state == S_IDLE) ? bus.req_wr_data                   : lat_wdata;

   assign bus.req_ready = (state == S_RESP);
   assign bus.busy      = (state != S_IDLE);
   assign bus.req_rdata = rdata_q;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (bus.req_valid) state_nxt = (LATENCY == 1) ? S_RESP : S_BUSY;
         S_BUSY: if (cnt == 8'd1)   state_nxt = S_RESP;
         S_RESP: state_nxt = S_DONE;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= 8'd0;
         lat_wr    <= 1'b0;
         lat_idx   <= '0;
         lat_wdata <= 32'h0;
         rdata_q   <= 32'h0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            cnt       <= CNT_LOAD;
            lat_wr    <= bus.req_wr;
            lat_idx   <= bus.req_addr[DEPTH_LOG2+1:2];
            lat_wdata <= bus.req_wr_data;
         end else if ((state == S_BUSY) && (cnt != 8'd0)) begin
            cnt <= cnt - 8'd1;
         end
         if (enter_resp && !acc_wr)
            rdata_q <= acc_oor ? 32'hDEAD_BEEF : mem[acc_idx];
      end
   end

   // Reset blocks the commit so an aborted write never lands.
   always_ff @(posedge clk) begin
      if (!rst && enter_resp && acc_wr && !acc_oor)
         mem[acc_idx] <= acc_wdata;
   end
endmodule

// File: tb/tb_main_mem_ctrl.sv
// Scoreboard bench for main_mem_ctrl: driver predicts each response from a
// word-array model; a negedge monitor checks every req_ready and busy.
module tb_main_mem_ctrl;
   localparam int DL   = 10;
   localparam int LAT  = 4;
   localparam int MAXC = 8192;

   typedef struct {
      int          exp_cyc;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   main_mem_ctrl_if bus();

   main_mem_ctrl #(.DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;
   int          next_free = 0;
   bit          mon_en = 1'b0;
   logic        prev_ready = 1'b0;
   logic [31:0] last_rdata = 32'h0;
   logic [31:0] mem_m [0:(1<<DL)-1];
   bit          busy_map [0:MAXC-1];
   exp_t        sbq [$];
   exp_t        mon_e;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h at cycle %0d", name, act, expv, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en && !rst) begin
         if (cyc < MAXC) check("busy", 32'(bus.busy), 32'(busy_map[cyc]));
         if (bus.req_ready) begin
            check("ready_width", 32'(prev_ready), 32'd0);
            if (sbq.size() == 0) begin
               check("spurious_ready", 32'(bus.req_ready), 32'd0);
            end else begin
               mon_e = sbq.pop_front();
               check("ready_cycle", 32'(cyc), 32'(mon_e.exp_cyc));
               check("rdata", bus.req_rdata, mon_e.rdata);
               check("err", 32'(bus.req_err), 32'(mon_e.err));
            end
         end else begin
            check("err_idle", 32'(bus.req_err), 32'd0);
            if (sbq.size() > 0 && sbq[0].exp_cyc <= cyc) begin
               check("missing_ready", 32'(bus.req_ready), 32'd1);
               void'(sbq.pop_front());
            end
         end
         prev_ready = bus.req_ready;
      end else begin
         prev_ready = 1'b0;
      end
   end

   function automatic bit out_of_range(input logic [31:0] addr);
      bit r;
      r = 1'b0;
`ifdef MEM_BOUND_CHK_EN
      r = (addr >> (DL + 2)) != 0;
`endif
      return r;
   endfunction

   // Called at a negedge; returns at the negedge of the response cycle.
   task automatic issue(input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input bit hold);
      int   a;
      int   idx;
      bit   oor;
      exp_t e;
      bus.req_valid   = 1'b1;
      bus.req_wr      = wr;
      bus.req_addr    = addr;
      bus.req_wr_data = data;
      a   = (cyc + 1 > next_free) ? cyc + 1 : next_free;
      idx = int'((addr >> 2) % (1 << DL));
      oor = out_of_range(addr);
      e.exp_cyc = a + LAT - 1;
      e.err     = oor;
      if (wr) begin
         if (!oor) mem_m[idx] = data;
         e.rdata = last_rdata;
      end else begin
         e.rdata    = oor ? 32'hDEAD_BEEF : mem_m[idx];
         last_rdata = e.rdata;
      end
      sbq.push_back(e);
      for (int k = a; k <= a + LAT && k < MAXC; k++) busy_map[k] = 1'b1;
      while (cyc < e.exp_cyc) @(negedge clk);
      if (!hold) bus.req_valid = 1'b0;
      next_free = e.exp_cyc + 3;
   endtask

   task automatic reset_midop(input logic [31:0] addr, input logic [31:0] data);
      int a;
      bus.req_valid   = 1'b1;
      bus.req_wr      = 1'b1;
      bus.req_addr    = addr;
      bus.req_wr_data = data;
      a = (cyc + 1 > next_free) ? cyc + 1 : next_free;
      for (int k = a; k <= a + 1 && k < MAXC; k++) busy_map[k] = 1'b1;
      while (cyc < a + 1) @(negedge clk);
      #1;
      rst           = 1'b1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      #1;
      rst        = 1'b0;
      last_rdata = 32'h0;
      next_free  = a + 3;
   endtask

   task automatic gap(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [31:0] addr;
      bit          hold;
      bit          held;
      for (int i = 0; i < (1 << DL); i++) mem_m[i] = 32'h0;
      for (int i = 0; i < MAXC; i++) busy_map[i] = 1'b0;
      bus.req_valid   = 1'b0;
      bus.req_wr      = 1'b0;
      bus.req_addr    = 32'h0;
      bus.req_wr_data = 32'h0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(bus.req_ready), 32'd0);
      check("rst_rdata", bus.req_rdata, 32'h0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_err", 32'(bus.req_err), 32'd0);
      rst    = 1'b0;
      mon_en = 1'b1;
      next_free = cyc + 1;
      gap(1);

      issue(1'b0, 32'h0000_0040, 32'h0, 1'b0);
      gap(1);
      issue(1'b1, 32'h0000_0010, 32'h1234_5678, 1'b0);
      issue(1'b0, 32'h0000_0010, 32'h0, 1'b0);
      gap(2);
      issue(1'b0, 32'h0000_0020, 32'h0, 1'b1);
      issue(1'b0, 32'h0000_0020, 32'h0, 1'b1);
      issue(1'b0, 32'h0000_0020, 32'h0, 1'b0);
      gap(2);
      reset_midop(32'h0000_0008, 32'hCAFE_F00D);
      gap(1);
      issue(1'b0, 32'h0000_0008, 32'h0, 1'b0);
      gap(1);
      issue(1'b1, 32'h0000_1000, 32'hAAAA_5555, 1'b0);
      issue(1'b0, 32'h0000_0000, 32'h0, 1'b0);
      issue(1'b0, 32'h0000_1000, 32'h0, 1'b0);

      held = 1'b0;
      for (int n = 0; n < 80; n++) begin
         if (!held) gap($urandom_range(0, 3));
         addr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) addr = addr | 32'h0000_1000;
         hold = ($urandom_range(0, 3) == 0);
         issue(1'($urandom_range(0, 1)), addr, $urandom, hold);
         held = hold;
      end
      bus.req_valid = 1'b0;
      gap(LAT + 4);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end
endmodule
